// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: step encodings, opcodes,
// instruction classes and the control-word bundle produced by the decoder.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        C_RTYPE, C_ITYPE, C_LDI, C_LD, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       mdr_out;
        logic       zlow_out;
        logic       zhigh_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       ba_out;
        logic       y_out;
        logic       pc_enable;
        logic       inc_pc;
        logic       mar_enable;
        logic       mdr_enable;
        logic       mdr_read;
        logic       ir_enable;
        logic       y_enable;
        logic       zlow_in;
        logic       zhigh_in;
        logic       hi_enable;
        logic       lo_enable;
        logic       outport_enable;
        logic       con_enable;
        logic       ram_write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [4:0] alu_op;
    } ctrl_t;

    // Unlisted opcodes fall into the nop class.
    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        c = C_NOP;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:      c = C_ITYPE;
            OP_LDI:                        c = C_LDI;
            OP_LD:                         c = C_LD;
            OP_ST:                         c = C_ST;
            OP_BR:                         c = C_BR;
            OP_JR:                         c = C_JR;
            OP_IN:                         c = C_IN;
            OP_OUT:                        c = C_OUT;
            OP_MFHI:                       c = C_MFHI;
            OP_MFLO:                       c = C_MFLO;
            OP_HALT:                       c = C_HALT;
            default:                       c = C_NOP;
        endcase
        return c;
    endfunction

    function automatic state_t last_step(input op_class_t c);
        state_t s;
        s = S_T3;
        case (c)
            C_LD, C_ST:               s = S_T7;
            C_BR:                     s = S_T6;
            C_RTYPE, C_ITYPE, C_LDI:  s = S_T5;
            default:                  s = S_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decode from the current step and latched opcode.
// CON_FF only matters in the branch write-back step.
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output ctrl_t      ctrl
);

    state_t    st;
    op_class_t cls;

    assign st  = state_t'(state);
    assign cls = op_class(opcode);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (st)
            S_T0: begin
                ctrl.pc_out     = 1'b1;
                ctrl.mar_enable = 1'b1;
                ctrl.inc_pc     = 1'b1;
                ctrl.pc_enable  = 1'b1;
            end
            S_T1: begin
                ctrl.mdr_read   = 1'b1;
                ctrl.mdr_enable = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out    = 1'b1;
                ctrl.ir_enable  = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_RTYPE, C_ITYPE: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_enable = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_enable = 1'b1;
                    end
                    C_BR: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.con_enable = 1'b1;
                    end
                    C_JR: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_enable = 1'b1;
                    end
                    C_IN: begin
                        ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    C_OUT: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_enable = 1'b1;
                    end
                    C_MFHI: begin
                        ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    C_MFLO: begin
                        ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_RTYPE: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_ITYPE: begin
                        ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    C_BR: begin
                        ctrl.pc_out = 1'b1; ctrl.y_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_RTYPE, C_ITYPE, C_LDI: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    C_LD, C_ST: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_enable = 1'b1;
                    end
                    C_BR: begin
                        ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        ctrl.mdr_read = 1'b1; ctrl.mdr_enable = 1'b1;
                    end
                    C_ST: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_enable = 1'b1;
                    end
                    C_BR: begin
                        ctrl.zlow_out  = 1'b1;
                        ctrl.pc_enable = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    C_ST: ctrl.ram_write = 1'b1;
                    default: ;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch T0-T2, opcode-dependent execute T3-T7,
// and a sticky HALT state left only through Clear.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Yout,
    output logic        PC_enable,
    output logic        IncPC,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        MDR_read,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        OutPort_enable,
    output logic        CON_enable,
    output logic        RAM_write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic        R_out,
    output logic [4:0]  alu_op,
    output logic [3:0]  state_dbg
);

    state_t     state;
    state_t     state_next;
    logic [4:0] opcode;
    op_class_t  cls;
    ctrl_t      dec;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];
    assign cls       = op_class(opcode);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= S_T0;
            opcode <= OP_NOP;
        end else begin
            state <= state_next;
            if (state == S_T2)
                opcode <= IR[31:27];
        end
    end

    // Stop is only looked at on an instruction's final step.
    always_comb begin
        state_next = state;
        case (state)
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_HALT: state_next = S_HALT;
            default: begin
                if (state == last_step(cls))
                    state_next = (cls == C_HALT || Stop) ? S_HALT : S_T0;
                else
                    state_next = state_t'(state + 4'd1);
            end
        endcase
    end

    control_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .con_ff (CON_FF),
        .ctrl   (dec)
    );

    // Clear silences every strobe immediately, without waiting for an edge.
    assign ctrl      = Clear ? dec : '0;
    assign Run       = Clear && (state != S_HALT);
    assign state_dbg = state;

    assign PCout          = ctrl.pc_out;
    assign MDRout         = ctrl.mdr_out;
    assign ZLowout        = ctrl.zlow_out;
    assign ZHighout       = ctrl.zhigh_out;
    assign HIout          = ctrl.hi_out;
    assign LOout          = ctrl.lo_out;
    assign InPortout      = ctrl.inport_out;
    assign Cout           = ctrl.c_out;
    assign BAout          = ctrl.ba_out;
    assign Yout           = ctrl.y_out;
    assign PC_enable      = ctrl.pc_enable;
    assign IncPC          = ctrl.inc_pc;
    assign MAR_enable     = ctrl.mar_enable;
    assign MDR_enable     = ctrl.mdr_enable;
    assign MDR_read       = ctrl.mdr_read;
    assign IR_enable      = ctrl.ir_enable;
    assign Y_enable       = ctrl.y_enable;
    assign ZLowIn         = ctrl.zlow_in;
    assign ZHighIn        = ctrl.zhigh_in;
    assign HI_enable      = ctrl.hi_enable;
    assign LO_enable      = ctrl.lo_enable;
    assign OutPort_enable = ctrl.outport_enable;
    assign CON_enable     = ctrl.con_enable;
    assign RAM_write      = ctrl.ram_write;
    assign Gra            = ctrl.gra;
    assign Grb            = ctrl.grb;
    assign Grc            = ctrl.grc;
    assign R_in           = ctrl.r_in;
    assign R_out          = ctrl.r_out;
    assign alu_op         = ctrl.alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction micro-step listings compared
// step by step, table vectors, random instructions and reset/halt sequences.
module tb_control_sequencer;

    localparam int W  = 35;
    localparam int NA = -1;
    typedef logic [W-1:0] word_t;

    localparam int B_RUN = 34, B_PCOUT = 33, B_MDROUT = 32, B_ZLOWOUT = 31,
                   B_ZHIGHOUT = 30, B_HIOUT = 29, B_LOOUT = 28, B_INPORTOUT = 27,
                   B_COUT = 26, B_BAOUT = 25, B_YOUT = 24, B_PCEN = 23,
                   B_INCPC = 22, B_MAREN = 21, B_MDREN = 20, B_MDRRD = 19,
                   B_IREN = 18, B_YEN = 17, B_ZLOWIN = 16, B_ZHIGHIN = 15,
                   B_HIEN = 14, B_LOEN = 13, B_OUTPORTEN = 12, B_CONEN = 11,
                   B_RAMWR = 10, B_GRA = 9, B_GRB = 8, B_GRC = 7, B_RIN = 6,
                   B_ROUT = 5;
    localparam logic [4:0] ADD = 5'b00011;

    logic        Clock, Clear, CON_FF, Stop;
    logic [31:0] IR;
    logic        Run, PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout;
    logic        Cout, BAout, Yout, PC_enable, IncPC, MAR_enable, MDR_enable;
    logic        MDR_read, IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable;
    logic        LO_enable, OutPort_enable, CON_enable, RAM_write;
    logic        Gra, Grb, Grc, R_in, R_out;
    logic [4:0]  alu_op;
    logic [3:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout),
        .ZHighout(ZHighout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .Cout(Cout), .BAout(BAout), .Yout(Yout), .PC_enable(PC_enable),
        .IncPC(IncPC), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
        .MDR_read(MDR_read), .IR_enable(IR_enable), .Y_enable(Y_enable),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .OutPort_enable(OutPort_enable),
        .CON_enable(CON_enable), .RAM_write(RAM_write), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .R_in(R_in), .R_out(R_out), .alu_op(alu_op),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic word_t observe();
        return {Run, PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout,
                Cout, BAout, Yout, PC_enable, IncPC, MAR_enable, MDR_enable,
                MDR_read, IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable,
                LO_enable, OutPort_enable, CON_enable, RAM_write, Gra, Grb, Grc,
                R_in, R_out, alu_op};
    endfunction

    function automatic word_t mk(input int a, input int b, input int c,
                                 input int d, input logic [4:0] alu);
        word_t r;
        r        = '0;
        r[B_RUN] = 1'b1;
        r[4:0]   = alu;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        if (d >= 0) r[d] = 1'b1;
        return r;
    endfunction

    task automatic check_word(input string name, input word_t got, input word_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: the micro-step listing of one instruction.
    task automatic model(input logic [4:0] op, input logic con, input logic stop,
                         output logic halts);
        exp_q.delete();
        halts = stop;
        exp_q.push_back(mk(B_PCOUT, B_MAREN, B_INCPC, B_PCEN, ADD));
        exp_q.push_back(mk(B_MDRRD, B_MDREN, NA, NA, ADD));
        exp_q.push_back(mk(B_MDROUT, B_IREN, NA, NA, ADD));
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
                exp_q.push_back(mk(B_GRB, B_ROUT, B_YEN, NA, ADD));
                exp_q.push_back(mk(B_GRC, B_ROUT, B_ZLOWIN, NA, op));
                exp_q.push_back(mk(B_ZLOWOUT, B_GRA, B_RIN, NA, ADD));
            end
            5'b01011, 5'b01100, 5'b01101: begin
                exp_q.push_back(mk(B_GRB, B_ROUT, B_YEN, NA, ADD));
                exp_q.push_back(mk(B_COUT, B_ZLOWIN, NA, NA, op));
                exp_q.push_back(mk(B_ZLOWOUT, B_GRA, B_RIN, NA, ADD));
            end
            5'b00001: begin
                exp_q.push_back(mk(B_GRB, B_BAOUT, B_YEN, NA, ADD));
                exp_q.push_back(mk(B_COUT, B_ZLOWIN, NA, NA, ADD));
                exp_q.push_back(mk(B_ZLOWOUT, B_GRA, B_RIN, NA, ADD));
            end
            5'b00000, 5'b00010: begin
                exp_q.push_back(mk(B_GRB, B_BAOUT, B_YEN, NA, ADD));
                exp_q.push_back(mk(B_COUT, B_ZLOWIN, NA, NA, ADD));
                exp_q.push_back(mk(B_ZLOWOUT, B_MAREN, NA, NA, ADD));
                if (op == 5'b00000) begin
                    exp_q.push_back(mk(B_MDRRD, B_MDREN, NA, NA, ADD));
                    exp_q.push_back(mk(B_MDROUT, B_GRA, B_RIN, NA, ADD));
                end else begin
                    exp_q.push_back(mk(B_GRA, B_ROUT, B_MDREN, NA, ADD));
                    exp_q.push_back(mk(B_RAMWR, NA, NA, NA, ADD));
                end
            end
            5'b10010: begin
                exp_q.push_back(mk(B_GRB, B_ROUT, B_CONEN, NA, ADD));
                exp_q.push_back(mk(B_PCOUT, B_YEN, NA, NA, ADD));
                exp_q.push_back(mk(B_COUT, B_ZLOWIN, NA, NA, ADD));
                exp_q.push_back(mk(B_ZLOWOUT, con ? B_PCEN : NA, NA, NA, ADD));
            end
            5'b10011: exp_q.push_back(mk(B_GRA, B_ROUT, B_PCEN, NA, ADD));
            5'b10101: exp_q.push_back(mk(B_INPORTOUT, B_GRA, B_RIN, NA, ADD));
            5'b10110: exp_q.push_back(mk(B_GRA, B_ROUT, B_OUTPORTEN, NA, ADD));
            5'b10111: exp_q.push_back(mk(B_HIOUT, B_GRA, B_RIN, NA, ADD));
            5'b11000: exp_q.push_back(mk(B_LOOUT, B_GRA, B_RIN, NA, ADD));
            5'b11010: begin
                exp_q.push_back(mk(NA, NA, NA, NA, ADD));
                halts = 1'b1;
            end
            default:  exp_q.push_back(mk(NA, NA, NA, NA, ADD));
        endcase
    endtask

    // Driver: entered shortly after a falling edge while the DUT sits in T0.
    task automatic run_instr(input string name, input logic [31:0] ir,
                             input logic con, input logic stop, input int exp_cycles);
        word_t obs, want;
        int    n, target;
        bit    done;
        logic  halts;
        IR = ir; CON_FF = con; Stop = stop;
        model(ir[31:27], con, stop, halts);
        target = (exp_cycles > 0) ? exp_cycles : exp_q.size();
        n = 0; done = 0;
        obs = observe();
        while (!done && n < 12) begin
            obs = observe();
            if (n > 0 && (!obs[B_RUN] || (obs[B_PCOUT] && obs[B_INCPC]))) begin
                done = 1;
            end else begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check_word($sformatf("%s step %0d", name, n), obs, want);
                n++;
                @(negedge Clock); #1;
            end
        end
        check_int({name, " cycles"}, n, target);
        check_int({name, " halted"}, int'(!obs[B_RUN]), int'(halts));
        Stop = 1'b0;
    endtask

    task automatic reset_pulse(input string name);
        Clear = 1'b0;
        #1 check_word({name, " clear async"}, observe(), '0);
        @(negedge Clock); #1;
        check_word({name, " clear held"}, observe(), '0);
        Clear = 1'b1;
        #1 check_word({name, " release T0"}, observe(),
                      mk(B_PCOUT, B_MAREN, B_INCPC, B_PCEN, ADD));
    endtask

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        logic        stop;
        int          cycles;
    } vec_t;

    vec_t vt[18];

    initial begin
        word_t       obs;
        logic [31:0] r;
        logic [4:0]  op;
        bit          saw_wr;

        vt[0]  = '{"addi",     32'h59080002, 1'b0, 1'b0, 6};
        vt[1]  = '{"ld",       32'h00000000, 1'b0, 1'b0, 8};
        vt[2]  = '{"st",       32'h10000000, 1'b1, 1'b0, 8};
        vt[3]  = '{"br_c0",    32'h90000000, 1'b0, 1'b0, 7};
        vt[4]  = '{"br_c1",    32'h90000000, 1'b1, 1'b0, 7};
        vt[5]  = '{"add",      32'h18000000, 1'b0, 1'b0, 6};
        vt[6]  = '{"sub",      32'h20000000, 1'b0, 1'b0, 6};
        vt[7]  = '{"ori",      32'h68000000, 1'b0, 1'b0, 6};
        vt[8]  = '{"ldi",      32'h08000000, 1'b0, 1'b0, 6};
        vt[9]  = '{"jr",       32'h98000000, 1'b0, 1'b0, 4};
        vt[10] = '{"in",       32'hA8000000, 1'b0, 1'b0, 4};
        vt[11] = '{"out",      32'hB0000000, 1'b0, 1'b0, 4};
        vt[12] = '{"mfhi",     32'hB8000000, 1'b0, 1'b0, 4};
        vt[13] = '{"mflo",     32'hC0000000, 1'b0, 1'b0, 4};
        vt[14] = '{"nop",      32'hC8000000, 1'b0, 1'b0, 4};
        vt[15] = '{"op11111",  32'hF8000000, 1'b0, 1'b0, 4};
        vt[16] = '{"and_stop", 32'h48000000, 1'b0, 1'b1, 6};
        vt[17] = '{"ld_stop",  32'h00000000, 1'b0, 1'b1, 8};

        Clear = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0;
        @(negedge Clock); #1;
        check_word("power-on clear", observe(), '0);
        @(negedge Clock); #1;
        Clear = 1'b1;
        #1 check_word("first release T0", observe(),
                      mk(B_PCOUT, B_MAREN, B_INCPC, B_PCEN, ADD));

        for (int i = 0; i < 18; i++) begin
            run_instr(vt[i].name, vt[i].ir, vt[i].con, vt[i].stop, vt[i].cycles);
            if (!Run) reset_pulse({vt[i].name, " restart"});
        end

        // halt opcode: frozen outputs while inputs wiggle, then Clear restarts
        run_instr("halt", 32'hD0000000, 1'b0, 1'b0, 4);
        for (int i = 0; i < 20; i++) begin
            IR = $urandom(); Stop = 1'(i % 2); CON_FF = 1'(i % 3 == 0);
            @(negedge Clock); #1;
            check_word($sformatf("halt frozen %0d", i), observe(), '0);
        end
        Stop = 1'b0;
        reset_pulse("halt restart");
        run_instr("after halt nop", 32'hC8000000, 1'b0, 1'b0, 4);

        // Clear in T5 of st abandons the store
        IR = 32'h10000000; CON_FF = 1'b0; saw_wr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock); #1;
        end
        check_word("st T5 before clear", observe(), mk(B_ZLOWOUT, B_MAREN, NA, NA, ADD));
        Clear = 1'b0;
        #1 check_word("st clear async", observe(), '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock); #1;
            obs = observe();
            if (obs[B_RAMWR]) saw_wr = 1;
        end
        check_int("st no RAM_write", int'(saw_wr), 0);
        Clear = 1'b1;
        #1 check_word("st clear release T0", observe(),
                      mk(B_PCOUT, B_MAREN, B_INCPC, B_PCEN, ADD));
        run_instr("refetch after st clear", 32'h59080002, 1'b0, 1'b0, 6);

        // Random instructions against the model
        for (int i = 0; i < 40; i++) begin
            r  = $urandom();
            op = 5'($urandom_range(0, 31));
            r[31:27] = op;
            run_instr($sformatf("rand%0d op%b", i, op), r, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), -1);
            if (!Run) reset_pulse($sformatf("rand%0d restart", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  in  1  system clock; all state changes on its rising edge.
REQ-002 Clear  in  1  reset, asynchronous, active-low.
REQ-003 IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-004 CON_FF  in  1  branch-condition flag from the datapath.
REQ-005 Stop  in  1  synchronous halt request.
REQ-006 Run  out  1  high while executing; low in HALT and during reset.
REQ-007 PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout, Yout  out  1 each  bus-drive selects.
REQ-008 PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable, LO_enable, OutPort_enable, CON_enable, RAM_write  out  1 each  register/memory strobes.
REQ-009 Gra, Grb, Grc, R_in, R_out  out  1 each  register-file field select and direction.
REQ-010 alu_op  out  5  ALU operation code; 5'b00011 (ADD) unless stated otherwise.

Function
REQ-011 The block SHALL be a Moore FSM; every output SHALL be decoded from the registered state and latched opcode only. All outputs not listed for a state SHALL be 0.
REQ-012 States: T0..T7, HALT. Each step SHALL last exactly one Clock cycle.
REQ-013 Fetch: T0 SHALL assert PCout, MAR_enable, IncPC, PC_enable. T1 SHALL assert MDR_read, MDR_enable. T2 SHALL assert MDRout, IR_enable.
REQ-014 Opcode SHALL be latched from IR[31:27] at the T2->T3 edge and held until the next T2.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, andi 01100, ori 01101, br 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Any other opcode SHALL execute as nop.
REQ-016 R-type (add/sub/and/or): T3 Grb, R_out, Y_enable. T4 Grc, R_out, ZLowIn, with alu_op=opcode. T5 ZLowout, Gra, R_in. Then T0.
REQ-017 I-type (addi/andi/ori): as REQ-016, except T4 asserts Cout instead of Grc/R_out, with alu_op=opcode.
REQ-018 ldi: T3 Grb, BAout, Y_enable. T4 Cout, ZLowIn. T5 ZLowout, Gra, R_in. Then T0.
REQ-019 ld: T3 and T4 as ldi. T5 ZLowout, MAR_enable. T6 MDR_read, MDR_enable. T7 MDRout, Gra, R_in. Then T0.
REQ-020 st: T3–T5 as ld. T6 Gra, R_out, MDR_enable with MDR_read=0. T7 RAM_write. Then T0.
REQ-021 br: T3 Grb, R_out, CON_enable. T4 PCout, Y_enable. T5 Cout, ZLowIn. T6 ZLowout, with PC_enable only if CON_FF=1 (sampled in T6). Then T0.
REQ-022 Single-step instructions, each then T0: jr T3 Gra, R_out, PC_enable. in T3 InPortout, Gra, R_in. out T3 Gra, R_out, OutPort_enable. mfhi T3 HIout, Gra, R_in. mflo T3 LOout, Gra, R_in. nop T3 with no strobes.
REQ-023 halt: T3 SHALL transition to HALT. HALT SHALL hold with all outputs 0 and Run=0 until Clear.
REQ-024 Stop=1 sampled on the final step of any instruction SHALL enter HALT instead of T0. Stop SHALL be ignored mid-instruction.
REQ-025 Each instruction SHALL complete in at most 8 cycles: ld/st 8, br 7, 3-step ops 6, single-step ops 4.

Reset
REQ-026 Clear=0 SHALL immediately force state T0, opcode nop, and Run=1 on release, with all strobes 0 while Clear=0.
REQ-027 Reset mid-instruction SHALL abandon the instruction; the first edge after release SHALL advance T0->T1.

Structure
REQ-028 Opcode constants, state encodings, and ALU_ADD SHALL reside in a shared package (cpu_pkg).
REQ-029 Output decode MAY be a sub-module (control_decode) that is purely combinational on state and opcode. The FSM register SHALL stay in control_sequencer.

Verification
REQ-030 IR=32'h59080002 (addi r2,r1,2): T4 Cout=1, ZLowIn=1, alu_op=01011. T5 ZLowout=1, Gra=1, R_in=1. Back to T0 after 6 cycles.
REQ-031 ld opcode: MAR_enable in T0 and T5, MDR_read in T1 and T6, Gra+R_in in T7, 8 cycles total.
REQ-032 br with CON_FF=0 then 1: PC_enable in T6 absent then present. Cycle count 7 both times.
REQ-033 halt opcode: HALT reached after T3, Run=0, outputs frozen for 20 cycles. Clear pulse restarts at T0.
REQ-034 Clear asserted during T5 of st: RAM_write never asserted, outputs 0 asynchronously, fetch restarts.
REQ-035 Opcode 11111: behaves as nop (T3 all 0) and returns to T0.
